// File: rtl/count_mem_pkg.sv
// ---------------------------------------------------------------------------
// count_mem_pkg
// Shared types and constants for the count sample store.
//   mode_t  : ordering of the store (last-in first-out / first-in first-out)
//   COUNT_W : native width of a captured counter value
// ---------------------------------------------------------------------------
package count_mem_pkg;

   typedef enum logic {
      MODE_LIFO = 1'b0,
      MODE_FIFO = 1'b1
   } mode_t;

   localparam int COUNT_W = 12;

endpackage : count_mem_pkg

// File: rtl/count_mem_ram.sv
// ---------------------------------------------------------------------------
// count_mem_ram
// Storage array for the count sample store. Combinational read, synchronous
// write, no reset (contents are don't-care until written).
// Ports:
//   clk    in   system clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational from raddr)
// ---------------------------------------------------------------------------
module count_mem_ram #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule : count_mem_ram

// File: rtl/count_memory.sv
// ---------------------------------------------------------------------------
// count_memory
// Parametrised store for captured counter values, written by the counter
// datapath and read back by the readout logic. Ordering is LIFO (a read
// returns the most recent count) or FIFO, selected by MODE.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   clear      in   synchronous clear (empties store, clears sticky flags)
//   write      in   store din this cycle
//   din        in   count value to store
//   read       in   retrieve one entry this cycle
//   dout       out  last retrieved entry, held between reads
//   dout_valid out  one-cycle pulse after a successful read
//   level      out  number of stored entries
//   empty      out  level == 0
//   full       out  level == DEPTH
//   overflow   out  sticky: a write was dropped
//   underflow  out  sticky: a read was refused
// ---------------------------------------------------------------------------
module count_memory
   import count_mem_pkg::*;
#(
   parameter int    WIDTH = COUNT_W,
   parameter int    DEPTH = 16,
   parameter mode_t MODE  = MODE_LIFO
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       write,
   input  logic [WIDTH-1:0]           din,
   input  logic                       read,
   output logic [WIDTH-1:0]           dout,
   output logic                       dout_valid,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       empty,
   output logic                       full,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int LW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);
   localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH-1);

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == PTR_MAX) ? '0 : p + 1'b1;
   endfunction

   logic [LW-1:0]    level_q, level_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic             full_w, empty_w;
   logic             rd_ok, wr_ok;
   logic [LW-1:0]    top;
   logic             ram_we;
   logic [AW-1:0]    ram_waddr, ram_raddr;
   logic [WIDTH-1:0] ram_rdata;

   count_mem_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (din),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   // Acceptance and addressing
   always_comb begin
      full_w  = (level_q == LVL_MAX);
      empty_w = (level_q == '0);
      rd_ok   = read && !empty_w;
      // A full store still accepts a write when a read frees a slot.
      wr_ok   = write && (!full_w || rd_ok);
      top     = level_q - LW'(1);
      ram_we  = wr_ok && !clear;
      if (MODE == MODE_FIFO) begin
         ram_raddr = rd_ptr_q;
         ram_waddr = wr_ptr_q;
      end else begin
         ram_raddr = empty_w ? '0 : top[AW-1:0];
         // Simultaneous read+write replaces the top entry; the read still
         // sees the old value because the array read is combinational.
         ram_waddr = rd_ok ? top[AW-1:0] : level_q[AW-1:0];
      end
   end

   // Next-state
   always_comb begin
      level_d      = level_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      overflow_d   = overflow_q;
      underflow_d  = underflow_q;
      if (clear) begin
         level_d     = '0;
         rd_ptr_d    = '0;
         wr_ptr_d    = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         level_d = level_q + LW'(wr_ok) - LW'(rd_ok);
         if (rd_ok) begin
            dout_d       = ram_rdata;
            dout_valid_d = 1'b1;
         end
         if (read && !rd_ok) begin
            underflow_d = 1'b1;
         end
         if (write && !wr_ok) begin
            overflow_d = 1'b1;
         end
         if (MODE == MODE_FIFO) begin
            if (rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         level_q      <= level_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign level      = level_q;
   assign empty      = (level_q == '0);
   assign full       = (level_q == LVL_MAX);
   assign overflow   = overflow_q;
   assign underflow  = underflow_q;

endmodule : count_memory

// File: tb/tb_count_memory.sv
// ---------------------------------------------------------------------------
// tb_count_memory
// Directed bench driving a LIFO and a FIFO instance (WIDTH=12, DEPTH=4)
// from the same stimulus and checking each against hand-computed values.
// ---------------------------------------------------------------------------
module tb_count_memory;
   import count_mem_pkg::*;

   logic        clk;
   logic        rst;
   logic        clear;
   logic        write;
   logic [11:0] din;
   logic        read;

   logic [11:0] l_dout, f_dout;
   logic        l_dv, f_dv;
   logic [2:0]  l_level, f_level;
   logic        l_empty, f_empty, l_full, f_full;
   logic        l_ovf, f_ovf, l_udf, f_udf;

   int n_cmp = 0;
   int n_err = 0;

   count_memory #(.WIDTH(12), .DEPTH(4), .MODE(MODE_LIFO)) dut_l (
      .clk(clk), .rst(rst), .clear(clear), .write(write), .din(din), .read(read),
      .dout(l_dout), .dout_valid(l_dv), .level(l_level), .empty(l_empty),
      .full(l_full), .overflow(l_ovf), .underflow(l_udf)
   );

   count_memory #(.WIDTH(12), .DEPTH(4), .MODE(MODE_FIFO)) dut_f (
      .clk(clk), .rst(rst), .clear(clear), .write(write), .din(din), .read(read),
      .dout(f_dout), .dout_valid(f_dv), .level(f_level), .empty(f_empty),
      .full(f_full), .overflow(f_ovf), .underflow(f_udf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock with the given inputs; returns #1 after the edge with inputs idle.
   task automatic step(input logic w, input logic [11:0] d, input logic r);
      write = w;
      din   = d;
      read  = r;
      @(posedge clk);
      #1;
      write = 1'b0;
      read  = 1'b0;
   endtask

   task automatic rd2(input string tag, input int el, input int ef);
      step(1'b0, 12'd0, 1'b1);
      chk({tag, " L dout"}, l_dout, el);
      chk({tag, " F dout"}, f_dout, ef);
      chk({tag, " L dv"}, l_dv, 1);
      chk({tag, " F dv"}, f_dv, 1);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; write = 1'b0; din = '0; read = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst L level", l_level, 0);
      chk("rst F empty", f_empty, 1);
      chk("rst L dout",  l_dout, 0);

      // Asynchronous reset mid-cycle
      step(1'b1, 12'd5, 1'b0);
      step(1'b0, 12'd0, 1'b1);
      chk("pre L dout", l_dout, 5);
      step(1'b1, 12'd6, 1'b0);
      step(1'b1, 12'd6, 1'b1);            // write to full? no: level 1, rd+wr
      chk("pre F level", f_level, 1);
      #3 rst = 1'b1;
      #1;
      chk("arst L dout",  l_dout, 0);
      chk("arst F dout",  f_dout, 0);
      chk("arst L level", l_level, 0);
      chk("arst F empty", f_empty, 1);
      chk("arst L full",  l_full, 0);
      chk("arst F ovf",   f_ovf, 0);
      chk("arst L udf",   l_udf, 0);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // Ordering
      step(1'b1, 12'd1591, 1'b0);
      step(1'b1, 12'd2099, 1'b0);
      rd2("ord1", 2099, 1591);
      rd2("ord2", 1591, 2099);
      chk("ord L empty", l_empty, 1);
      chk("ord F empty", f_empty, 1);
      step(1'b0, 12'd0, 1'b0);
      chk("ord L dv drop", l_dv, 0);
      chk("ord F dout hold", f_dout, 2099);

      // Pointer wrap (FIFO pointers start at 2 here)
      step(1'b1, 12'd10, 1'b0);
      step(1'b1, 12'd11, 1'b0);
      step(1'b1, 12'd12, 1'b0);
      rd2("wrap1", 12, 10);
      rd2("wrap2", 11, 11);
      step(1'b1, 12'd13, 1'b0);
      step(1'b1, 12'd14, 1'b0);
      step(1'b1, 12'd15, 1'b0);
      chk("wrap L full", l_full, 1);
      chk("wrap F full", f_full, 1);
      chk("wrap F level", f_level, 4);
      rd2("wrap3", 15, 12);
      rd2("wrap4", 14, 13);
      rd2("wrap5", 13, 14);
      rd2("wrap6", 10, 15);
      chk("wrap F empty", f_empty, 1);

      // Full / overflow
      for (int i = 1; i <= 4; i++) step(1'b1, 12'(i), 1'b0);
      chk("full L full", l_full, 1);
      chk("full F full", f_full, 1);
      chk("full L ovf0", l_ovf, 0);
      step(1'b1, 12'd5, 1'b0);
      chk("ovf L ovf", l_ovf, 1);
      chk("ovf F ovf", f_ovf, 1);
      chk("ovf L level", l_level, 4);
      step(1'b1, 12'd9, 1'b1);
      chk("rw L level", l_level, 4);
      chk("rw F level", f_level, 4);
      chk("rw L dout", l_dout, 4);
      chk("rw F dout", f_dout, 1);
      rd2("rw2", 9, 2);
      clear = 1'b1;
      step(1'b1, 12'd77, 1'b1);
      clear = 1'b0;
      chk("clr L level", l_level, 0);
      chk("clr F ovf", f_ovf, 0);
      chk("clr L dout", l_dout, 9);
      chk("clr F dout", f_dout, 2);
      chk("clr F dv", f_dv, 0);

      // Empty / underflow
      step(1'b0, 12'd0, 1'b1);
      chk("udf L udf", l_udf, 1);
      chk("udf F udf", f_udf, 1);
      chk("udf L dout", l_dout, 9);
      chk("udf F dv", f_dv, 0);
      step(1'b1, 12'd7, 1'b1);
      chk("udfrw L level", l_level, 1);
      chk("udfrw F level", f_level, 1);
      chk("udfrw L dv", l_dv, 0);
      rd2("udf7", 7, 7);
      clear = 1'b1;
      step(1'b0, 12'd0, 1'b0);
      clear = 1'b0;
      chk("clr2 L udf", l_udf, 0);
      chk("clr2 F level", f_level, 0);
      chk("clr2 F dout", f_dout, 7);

      // Reset mid-operation
      step(1'b1, 12'd1, 1'b0);
      step(1'b1, 12'd2, 1'b0);
      step(1'b1, 12'd3, 1'b0);
      chk("mid L level", l_level, 3);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("mid L level0", l_level, 0);
      chk("mid F empty", f_empty, 1);
      step(1'b1, 12'd42, 1'b0);
      rd2("mid42", 42, 42);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_count_memory
